bcd_timer_display: RTL

- Parametrised N-digit BCD up/down counter with a programmable tick prescaler and per-digit active-low 7-segment decode.
- Successor to the fixed 2-digit, 1 Hz, count-up-only seconds display.
- Adds direction control, load, clear, wrap/saturate modes, a terminal-count flag and leading-zero blanking.
- Drives DE-series HEX displays for game timers and score readouts in the top level.

---
 rtl/bcd_timer_display_if.sv | 25 ++
 rtl/bcd_timer_display.sv | 137 +++++++++++++
 2 files changed

// File: rtl/bcd_timer_display_if.sv
// Control and display bundle for bcd_timer_display.
// The master drives the count controls; the slave (the timer) returns the count and segment data.
interface bcd_timer_display_if #(
    parameter int DIGITS = 2
);
    logic                  enable;
    logic                  clear;
    logic                  load;
    logic [4*DIGITS-1:0]   load_value;
    logic                  count_down;
    logic [4*DIGITS-1:0]   bcd_value;
    logic [7*DIGITS-1:0]   hex;
    logic                  tick_out;
    logic                  terminal;

    modport master (
        output enable, clear, load, load_value, count_down,
        input  bcd_value, hex, tick_out, terminal
    );

    modport slave (
        input  enable, clear, load, load_value, count_down,
        output bcd_value, hex, tick_out, terminal
    );
endinterface

// File: rtl/bcd_timer_display.sv
// N-digit BCD up/down counter with a tick prescaler, wrap/saturate limits and
// per-digit active-low 7-segment decode with optional leading-zero blanking.
module bcd_timer_display #(
    parameter int DIGITS        = 2,
    parameter int TICK_CYCLES   = 50000000,
    parameter int WRAP          = 1,
    parameter int BLANK_LEADING = 0
) (
    input  logic                CLOCK_50,
    input  logic                resetn,
    bcd_timer_display_if.slave  bus
);
    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0]         PRE_LAST  = PW'(TICK_CYCLES - 1);
    localparam logic [4*DIGITS-1:0]   ALL_NINES = {DIGITS{4'h9}};

    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic [PW-1:0]       pre_q, pre_d;
    logic                tick_q, tick_d;

    logic [4*DIGITS-1:0] step_val;
    logic [4*DIGITS-1:0] load_clamped;
    logic                carry;
    logic [3:0]          digit;

    // Next count value: ripple carry (up) or borrow (down) through the digits.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        step_val = bcd_q;
        carry    = 1'b1;
        digit    = 4'd0;
        for (int k = 0; k < DIGITS; k++) begin
            digit = bcd_q[4*k +: 4];
            if (carry) begin
                if (!bus.count_down) begin
                    if (digit == 4'd9) begin
                        step_val[4*k +: 4] = 4'd0;
                    end else begin
                        step_val[4*k +: 4] = digit + 4'd1;
                        carry              = 1'b0;
                    end
                end else begin
                    if (digit == 4'd0) begin
                        step_val[4*k +: 4] = 4'd9;
                    end else begin
                        step_val[4*k +: 4] = digit - 4'd1;
                        carry              = 1'b0;
                    end
                end
            end
        end
        // Carry out of the top digit means the count sat at its limit.
        if (carry) begin
            if (WRAP != 0) step_val = bus.count_down ? ALL_NINES : '0;
            else           step_val = bcd_q;
        end
    end

    always_comb begin
        load_clamped = '0;
        for (int k = 0; k < DIGITS; k++) begin
            load_clamped[4*k +: 4] = (bus.load_value[4*k +: 4] > 4'd9) ? 4'd9
                                                                      : bus.load_value[4*k +: 4];
        end
    end

    always_comb begin
        bcd_d  = bcd_q;
        pre_d  = pre_q;
        tick_d = 1'b0;
        if (bus.clear) begin
            bcd_d = '0;
            pre_d = '0;
        end else if (bus.load) begin
            bcd_d = load_clamped;
            pre_d = '0;
        end else if (bus.enable) begin
            if (pre_q == PRE_LAST) begin
                pre_d  = '0;
                bcd_d  = step_val;
                tick_d = 1'b1;
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            bcd_q  <= '0;
            pre_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            bcd_q  <= bcd_d;
            pre_q  <= pre_d;
            tick_q <= tick_d;
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    logic [7*DIGITS-1:0] hex_c;
    logic                zero_above;

    // Walk from the most significant digit down; a digit blanks while it and everything above it is zero.
    always_comb begin
        hex_c      = '1;
        zero_above = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_above = zero_above && (bcd_q[4*k +: 4] == 4'd0);
            if ((BLANK_LEADING != 0) && (k > 0) && zero_above)
                hex_c[7*k +: 7] = 7'b1111111;
            else
                hex_c[7*k +: 7] = seg7(bcd_q[4*k +: 4]);
        end
    end

    assign bus.bcd_value = bcd_q;
    assign bus.tick_out  = tick_q;
    assign bus.hex       = hex_c;
    assign bus.terminal  = bus.count_down ? (bcd_q == '0) : (bcd_q == ALL_NINES);
endmodule
